// File: rtl/framing_decoding.sv
// -----------------------------------------------------------------------------
// framing_decoding
//   Receive-side frame sync and byte recovery for the PHY. Consumes a serial
//   bitstream (LSB-first per byte) of preamble zeros, SFD, PHR and PSDU.
//   It locks on SFD after enough zeros, then emits the PHR byte and the PSDU
//   bytes to the MAC side with a one-cycle byte strobe.
//
//   Optional feature macro: FRAMING_DECODING_CRC_EN
//     defined   -> bit-serial CRC-16 (x^16+x^12+x^5+1, init 0, LSB-first) over
//                  all PSDU bits including the trailing FCS; crc_ok is valid
//                  with frame_end.
//     undefined -> no CRC logic; crc_ok is tied low.
//
// Ports
//   clk                        in   1  rising-edge clock
//   reset                      in   1  synchronous, active-high
//   framing_decoding_in        in   1  serial input bit
//   framing_decoding_in_valid  in   1  input bit is consumed only when high
//   phr_psdu_out               out  8  recovered byte, held between strobes
//   phr_psdu_out_valid         out  1  one-cycle strobe per recovered byte
//   phr_flag                   out  1  strobe carries the PHR byte
//   frame_end                  out  1  strobe carries the last PSDU byte
//   len_err                    out  1  PHR length field was zero
//   sync_locked                out  1  high while in PHR or PSDU state
//   crc_ok                     out  1  FCS check result, valid with frame_end
// -----------------------------------------------------------------------------
module framing_decoding #(
  parameter int          SYNC_ZEROS = 32,
  parameter logic [7:0]  SFD_BYTE   = 8'hA7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       framing_decoding_in,
  input  logic       framing_decoding_in_valid,
  output logic [7:0] phr_psdu_out,
  output logic       phr_psdu_out_valid,
  output logic       phr_flag,
  output logic       frame_end,
  output logic       len_err,
  output logic       sync_locked,
  output logic       crc_ok
);

  localparam logic [5:0] LP_SYNC = 6'(SYNC_ZEROS);

  typedef enum logic [1:0] {S_HUNT, S_SFD, S_PHR, S_PSDU} state_t;

  state_t     r_state,     w_state_nxt;
  logic [5:0] r_zero_cnt,  w_zero_cnt_nxt;
  logic [2:0] r_bit_cnt,   w_bit_cnt_nxt;
  logic [6:0] r_byte_cnt,  w_byte_cnt_nxt;
  logic [7:0] r_shift;
  logic [7:0] r_out,       w_out_nxt;
  logic       r_out_valid, w_out_valid_nxt;
  logic       r_phr_flag,  w_phr_flag_nxt;
  logic       r_frame_end, w_frame_end_nxt;
  logic       r_len_err,   w_len_err_nxt;

  // Byte as it will look once the current input bit is shifted in at bit 7.
  logic [7:0] w_byte;
  logic       w_byte_done;
  assign w_byte      = {framing_decoding_in, r_shift[7:1]};
  assign w_byte_done = (r_bit_cnt == 3'd7);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_state_nxt     = r_state;
    w_zero_cnt_nxt  = r_zero_cnt;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_byte_cnt_nxt  = r_byte_cnt;
    w_out_nxt       = r_out;
    w_out_valid_nxt = 1'b0;
    w_phr_flag_nxt  = 1'b0;
    w_frame_end_nxt = 1'b0;
    w_len_err_nxt   = 1'b0;

    if (framing_decoding_in_valid) begin
      // The 3-bit counter wraps to 0 on the 8th bit of every byte.
      w_bit_cnt_nxt = r_bit_cnt + 3'd1;
      unique case (r_state)
        S_HUNT: begin
          w_bit_cnt_nxt = '0;
          if (!framing_decoding_in) begin
            if (r_zero_cnt != LP_SYNC) w_zero_cnt_nxt = r_zero_cnt + 6'd1;
          end else begin
            w_zero_cnt_nxt = '0;
            // The first 1 after the preamble is bit 0 of the SFD.
            if (r_zero_cnt == LP_SYNC) begin
              w_state_nxt   = S_SFD;
              w_bit_cnt_nxt = 3'd1;
            end
          end
        end
        S_SFD: begin
          if (w_byte_done) w_state_nxt = (w_byte == SFD_BYTE) ? S_PHR : S_HUNT;
        end
        S_PHR: begin
          if (w_byte_done) begin
            w_out_nxt       = w_byte;
            w_out_valid_nxt = 1'b1;
            w_phr_flag_nxt  = 1'b1;
            // Bit 7 is reserved: passed through but not part of the length.
            if (w_byte[6:0] == 7'd0) begin
              w_len_err_nxt = 1'b1;
              w_state_nxt   = S_HUNT;
            end else begin
              w_byte_cnt_nxt = w_byte[6:0];
              w_state_nxt    = S_PSDU;
            end
          end
        end
        S_PSDU: begin
          if (w_byte_done) begin
            w_out_nxt       = w_byte;
            w_out_valid_nxt = 1'b1;
            w_byte_cnt_nxt  = r_byte_cnt - 7'd1;
            if (r_byte_cnt == 7'd1) begin
              w_frame_end_nxt = 1'b1;
              w_state_nxt     = S_HUNT;
            end
          end
        end
        default: w_state_nxt = S_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      r_state     <= S_HUNT;
      r_zero_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_shift     <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_phr_flag  <= 1'b0;
      r_frame_end <= 1'b0;
      r_len_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_zero_cnt  <= w_zero_cnt_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_byte_cnt  <= w_byte_cnt_nxt;
      if (framing_decoding_in_valid) r_shift <= w_byte;
      r_out       <= w_out_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_phr_flag  <= w_phr_flag_nxt;
      r_frame_end <= w_frame_end_nxt;
      r_len_err   <= w_len_err_nxt;
    end
  end

`ifdef FRAMING_DECODING_CRC_EN
  // Reflected CRC-16 (0x8408 is x^16+x^12+x^5+1 bit-reversed), LSB-first.
  // Running the FCS through the register leaves a zero residue on a good frame.
  logic [15:0] r_crc;
  logic [15:0] w_crc_step;
  logic        w_crc_fb;
  logic        w_enter_psdu;
  logic        w_psdu_bit;
  logic        r_crc_ok;

  assign w_crc_fb     = framing_decoding_in ^ r_crc[0];
  assign w_crc_step   = {1'b0, r_crc[15:1]} ^ (w_crc_fb ? 16'h8408 : 16'h0000);
  assign w_enter_psdu = (r_state == S_PHR) && (w_state_nxt == S_PSDU);
  assign w_psdu_bit   = framing_decoding_in_valid && (r_state == S_PSDU);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_crc    <= '0;
      r_crc_ok <= 1'b0;
    end else begin
      r_crc_ok <= w_frame_end_nxt && (w_crc_step == 16'h0000);
      if (w_enter_psdu)    r_crc <= '0;
      else if (w_psdu_bit) r_crc <= w_crc_step;
    end
  end

  assign crc_ok = r_crc_ok;
`else
  assign crc_ok = 1'b0;
`endif

  assign phr_psdu_out       = r_out;
  assign phr_psdu_out_valid = r_out_valid;
  assign phr_flag           = r_phr_flag;
  assign frame_end          = r_frame_end;
  assign len_err            = r_len_err;
  assign sync_locked        = (r_state == S_PHR) || (r_state == S_PSDU);

endmodule

// File: tb/tb_framing_decoding.sv
// -----------------------------------------------------------------------------
// tb_framing_decoding
//   Directed self-checking bench for framing_decoding. A negedge monitor logs
//   every byte strobe with its flags and cycle stamp; each scenario task
//   drives a bitstream and compares the logged strobes against hand-computed
//   bytes, flags and timing. Expected crc_ok follows FRAMING_DECODING_CRC_EN.
// -----------------------------------------------------------------------------
module tb_framing_decoding;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic [7:0] phr_psdu_out;
  logic       phr_psdu_out_valid;
  logic       phr_flag;
  logic       frame_end;
  logic       len_err;
  logic       sync_locked;
  logic       crc_ok;

  framing_decoding dut (
    .clk                       (clk),
    .reset                     (reset),
    .framing_decoding_in       (din),
    .framing_decoding_in_valid (din_valid),
    .phr_psdu_out              (phr_psdu_out),
    .phr_psdu_out_valid        (phr_psdu_out_valid),
    .phr_flag                  (phr_flag),
    .frame_end                 (frame_end),
    .len_err                   (len_err),
    .sync_locked               (sync_locked),
    .crc_ok                    (crc_ok)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       phr;
    logic       fe;
    logic       le;
    logic       crc;
    int         cyc;
  } strobe_t;

  strobe_t q[$];
  int      locked_cnt = 0;
  int      stray_cnt  = 0;

  always @(negedge clk) begin
    strobe_t s;
    if (phr_psdu_out_valid) begin
      s.data = phr_psdu_out;
      s.phr  = phr_flag;
      s.fe   = frame_end;
      s.le   = len_err;
      s.crc  = crc_ok;
      s.cyc  = cyc;
      q.push_back(s);
    end else if (phr_flag || frame_end || len_err || crc_ok) begin
      stray_cnt++;
    end
    if (sync_locked) locked_cnt++;
  end

  int         n_vec = 0;
  int         n_err = 0;
  int         last_cap;
  int         cap_q[$];
  logic [7:0] fb_q[$];

`ifdef FRAMING_DECODING_CRC_EN
  localparam logic CRC_GOOD = 1'b1;
`else
  localparam logic CRC_GOOD = 1'b0;
`endif

  // Reference CRC-16 x^16+x^12+x^5+1, init 0, bytes fed LSB-first.
  function automatic logic [15:0] crc16(input logic [7:0] bytes[$]);
    logic [15:0] c = 16'h0000;
    logic        fb;
    foreach (bytes[k]) begin
      for (int i = 0; i < 8; i++) begin
        fb = c[0] ^ bytes[k][i];
        c  = c >> 1;
        if (fb) c = c ^ 16'h8408;
      end
    end
    return c;
  endfunction

  // One valid bit, then `gap` invalid cycles carrying a 1 that must be ignored.
  task automatic send_bit(input logic b, input int gap);
    @(negedge clk);
    din = b;
    din_valid = 1'b1;
    last_cap = cyc + 1;
    repeat (gap) begin
      @(negedge clk);
      din = 1'b1;
      din_valid = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int i = 0; i < 8; i++) send_bit(b[i], gap);
    cap_q.push_back(last_cap);
  endtask

  // Preamble zeros then every byte of fb_q (SFD included).
  task automatic send_frame(input int zeros, input int gap);
    cap_q.delete();
    for (int i = 0; i < zeros; i++) send_bit(1'b0, gap);
    foreach (fb_q[k]) send_byte(fb_q[k], gap);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din = 1'b0;
      din_valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle(3);
    n_vec++;
    if ({phr_psdu_out, phr_psdu_out_valid, phr_flag, frame_end, len_err, sync_locked, crc_ok} !== 14'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 0", {phr_psdu_out, phr_psdu_out_valid, phr_flag, frame_end, len_err, sync_locked, crc_ok});
    end
    reset = 1'b0;
    idle(2);
  endtask

  // Shared by the continuous and stalled runs of the reference frame.
  task automatic test_ref_frame(input string tag, input int gap);
    logic [7:0] exp_d[6] = '{8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    int base = q.size();
    fb_q = '{8'hA7, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_frame(32, gap);
    idle(4 * (gap + 1));
    n_vec++;
    if (q.size() - base !== 6) begin
      n_err++;
      $display("FAIL %s_count: got %0d strobes expected 6", tag, q.size() - base);
    end
    for (int i = 0; i < 6 && base + i < q.size(); i++) begin
      n_vec++;
      if ({q[base+i].data, q[base+i].phr, q[base+i].fe, q[base+i].le} !== {exp_d[i], i == 0, i == 5, 1'b0}) begin
        n_err++;
        $display("FAIL %s_byte%0d: got %h/%b%b%b expected %h/%b%b0", tag, i,
                 q[base+i].data, q[base+i].phr, q[base+i].fe, q[base+i].le, exp_d[i], i == 0, i == 5);
      end
      n_vec++;
      if (q[base+i].cyc !== cap_q[i+1]) begin
        n_err++;
        $display("FAIL %s_latency%0d: got cycle %0d expected %0d", tag, i, q[base+i].cyc, cap_q[i+1]);
      end
      if (i > 0) begin
        n_vec++;
        if (q[base+i].cyc - q[base+i-1].cyc !== 8 * (gap + 1)) begin
          n_err++;
          $display("FAIL %s_spacing%0d: got %0d expected %0d", tag, i, q[base+i].cyc - q[base+i-1].cyc, 8 * (gap + 1));
        end
      end
    end
    n_vec++;
    if ({phr_psdu_out, sync_locked} !== {8'h05, 1'b0}) begin
      n_err++;
      $display("FAIL %s_hold: got out=%h locked=%b expected out=05 locked=0", tag, phr_psdu_out, sync_locked);
    end
  endtask

  task automatic test_short_preamble;
    int base = q.size();
    int lk = locked_cnt;
    fb_q = '{8'hA7, 8'h03, 8'h01, 8'h02, 8'h03};
    send_frame(31, 0);
    idle(4);
    n_vec++;
    if (q.size() - base !== 0 || locked_cnt !== lk) begin
      n_err++;
      $display("FAIL short_preamble: got %0d strobes, %0d locked cycles expected 0, 0", q.size() - base, locked_cnt - lk);
    end
  endtask

  task automatic test_bad_sfd;
    int base = q.size();
    int lk = locked_cnt;
    // 0xA6 starts with a 0, so the SFD capture begins at its bit 1 and borrows
    // one bit from the following zeros; send 33 so 32 remain for the next lock.
    fb_q = '{8'hA6};
    send_frame(32, 0);
    idle(2);
    n_vec++;
    if (q.size() - base !== 0 || locked_cnt !== lk) begin
      n_err++;
      $display("FAIL bad_sfd_reject: got %0d strobes, %0d locked cycles expected 0, 0", q.size() - base, locked_cnt - lk);
    end
    fb_q = '{8'hA7, 8'h01, 8'h5A};
    send_frame(33, 0);
    idle(4);
    n_vec++;
    if (q.size() - base !== 2) begin
      n_err++;
      $display("FAIL bad_sfd_recover_count: got %0d strobes expected 2", q.size() - base);
    end else begin
      n_vec++;
      if ({q[base].data, q[base].phr, q[base].fe, q[base+1].data, q[base+1].phr, q[base+1].fe} !==
          {8'h01, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b1}) begin
        n_err++;
        $display("FAIL bad_sfd_recover_bytes: got %h %b%b %h %b%b expected 01 10 5a 01",
                 q[base].data, q[base].phr, q[base].fe, q[base+1].data, q[base+1].phr, q[base+1].fe);
      end
    end
  endtask

  task automatic test_len_zero;
    int base = q.size();
    fb_q = '{8'hA7, 8'h00};
    send_frame(32, 0);
    idle(4);
    n_vec++;
    if (q.size() - base !== 1) begin
      n_err++;
      $display("FAIL len_zero_count: got %0d strobes expected 1", q.size() - base);
    end else begin
      n_vec++;
      if ({q[base].data, q[base].phr, q[base].le, q[base].fe} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL len_zero_flags: got %h phr=%b le=%b fe=%b expected 00 phr=1 le=1 fe=0",
                 q[base].data, q[base].phr, q[base].le, q[base].fe);
      end
    end
    n_vec++;
    if (sync_locked !== 1'b0) begin
      n_err++;
      $display("FAIL len_zero_unlock: got sync_locked=%b expected 0", sync_locked);
    end
  endtask

  task automatic test_reset_mid_frame;
    int base = q.size();
    int fe_seen = 0;
    fb_q = '{8'hA7, 8'h05, 8'h01, 8'h02};
    send_frame(32, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    send_bit(1'b0, 0);
    @(negedge clk);
    n_vec++;
    if (sync_locked !== 1'b1) begin
      n_err++;
      $display("FAIL mid_locked: got %b expected 1", sync_locked);
    end
    reset = 1'b1;
    din_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({phr_psdu_out, phr_psdu_out_valid, phr_flag, frame_end, len_err, sync_locked, crc_ok} !== 14'h0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: got %h expected 0", {phr_psdu_out, phr_psdu_out_valid, phr_flag, frame_end, len_err, sync_locked, crc_ok});
    end
    reset = 1'b0;
    idle(20);
    for (int i = base; i < q.size(); i++) if (q[i].fe) fe_seen++;
    n_vec++;
    if (q.size() - base !== 3 || fe_seen !== 0) begin
      n_err++;
      $display("FAIL mid_reset_discard: got %0d strobes, %0d frame_end expected 3, 0", q.size() - base, fe_seen);
    end
    test_ref_frame("after_reset", 0);
  endtask

  task automatic test_crc;
    logic [7:0] msg[$] = '{8'h01, 8'h02, 8'h03};
    logic [15:0] fcs = crc16(msg);
    int base;
    for (int pass = 0; pass < 2; pass++) begin
      base = q.size();
      // Second pass corrupts bit 2 of the last payload byte, keeping the FCS.
      fb_q = '{8'hA7, 8'h05, 8'h01, 8'h02, (pass == 0) ? 8'h03 : 8'h07, fcs[7:0], fcs[15:8]};
      send_frame(32, 0);
      idle(4);
      n_vec++;
      if (q.size() - base !== 6) begin
        n_err++;
        $display("FAIL crc%0d_count: got %0d strobes expected 6", pass, q.size() - base);
      end else begin
        n_vec++;
        if ({q[base+5].fe, q[base+5].crc} !== {1'b1, (pass == 0) ? CRC_GOOD : 1'b0}) begin
          n_err++;
          $display("FAIL crc%0d_result: got fe=%b crc_ok=%b expected fe=1 crc_ok=%b",
                   pass, q[base+5].fe, q[base+5].crc, (pass == 0) ? CRC_GOOD : 1'b0);
        end
        n_vec++;
        if ({q[base].crc, q[base+1].crc, q[base+2].crc, q[base+3].crc, q[base+4].crc} !== 5'b0) begin
          n_err++;
          $display("FAIL crc%0d_early: crc_ok high before frame_end", pass);
        end
      end
    end
    n_vec++;
    if (stray_cnt !== 0) begin
      n_err++;
      $display("FAIL stray_flags: got %0d flag cycles without strobe expected 0", stray_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_ref_frame("basic", 0);
    test_short_preamble;
    test_bad_sfd;
    test_ref_frame("stall", 3);
    test_len_zero;
    test_reset_mid_frame;
    test_crc;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
